// File: rtl/vend_controller_if.sv
// Board-side bundle for the vending controller: coin/button inputs, dispenser
// and hopper handshakes, and the credit/status outputs.
interface vend_if;
    logic [3:0] coin_in;
    logic [2:0] sel;
    logic       buy;
    logic       refund;
    logic       disp_done;
    logic       coin_ack;
    logic       disp_req;
    logic [2:0] disp_sel;
    logic       coin_req;
    logic [4:0] coin_val;
    logic [7:0] credit;
    logic       busy;
    logic       coin_rej;
    logic       err;

    modport slave (
        input  coin_in, sel, buy, refund, disp_done, coin_ack,
        output disp_req, disp_sel, coin_req, coin_val, credit, busy, coin_rej, err
    );
    modport master (
        output coin_in, sel, buy, refund, disp_done, coin_ack,
        input  disp_req, disp_sel, coin_req, coin_val, credit, busy, coin_rej, err
    );
endinterface

// File: rtl/vend_controller.sv
// Vending transaction sequencer: credit accumulation, purchase validation,
// dispenser handshake with timeout, and coin-by-coin change payout.
module vend_controller #(
    parameter logic [3:0] PRICE0       = 4'd7,
    parameter logic [3:0] PRICE1       = 4'd5,
    parameter logic [3:0] PRICE2       = 4'd6,
    parameter logic [3:0] PRICE3       = 4'd10,
    parameter logic [3:0] PRICE4       = 4'd8,
    parameter int         CREDIT_MAX   = 79,
    parameter int         DISP_TIMEOUT = 255
) (
    input  logic  i_clk,
    input  logic  i_rst,
    vend_if.slave io_vend
);
    localparam int TW = $clog2(DISP_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, DISPENSE, CHANGE, PAY} state_t;

    state_t        r_state, w_state;
    logic [7:0]    r_credit, w_credit;
    logic [2:0]    r_disp_sel, w_disp_sel;
    logic [4:0]    r_coin_val, w_coin_val;
    logic [TW-1:0] r_tmo, w_tmo;
    logic          r_disp_req, r_coin_req, r_busy, r_coin_rej, r_err;
    logic          w_rej, w_err, w_has_coin;
    logic [4:0]    w_coin;
    logic [8:0]    w_sum;
    logic [7:0]    w_price, w_dprice;

    function automatic logic [3:0] f_price(input logic [2:0] s);
        case (s)
            3'd0:    f_price = PRICE0;
            3'd1:    f_price = PRICE1;
            3'd2:    f_price = PRICE2;
            3'd3:    f_price = PRICE3;
            3'd4:    f_price = PRICE4;
            default: f_price = 4'd0;
        endcase
    endfunction

    function automatic logic [4:0] f_change(input logic [7:0] c);
        if (c >= 8'd20)      f_change = 5'd20;
        else if (c >= 8'd10) f_change = 5'd10;
        else if (c >= 8'd5)  f_change = 5'd5;
        else                 f_change = 5'd1;
    endfunction

    // Only the highest coin bit counts when several switches fire together.
    always_comb begin
        w_coin = 5'd0;
        if (io_vend.coin_in[3])      w_coin = 5'd20;
        else if (io_vend.coin_in[2]) w_coin = 5'd10;
        else if (io_vend.coin_in[1]) w_coin = 5'd5;
        else if (io_vend.coin_in[0]) w_coin = 5'd1;
    end

    assign w_has_coin = |io_vend.coin_in;
    assign w_sum      = {1'b0, r_credit} + {4'd0, w_coin};
    assign w_price    = {4'd0, f_price(io_vend.sel)};
    assign w_dprice   = {4'd0, f_price(r_disp_sel)};

    always_comb begin
        w_state    = r_state;
        w_credit   = r_credit;
        w_disp_sel = r_disp_sel;
        w_coin_val = r_coin_val;
        w_tmo      = r_tmo;
        w_rej      = 1'b0;
        w_err      = 1'b0;
        case (r_state)
            IDLE: begin
                w_tmo = '0;
                if (io_vend.refund) begin
                    w_rej = w_has_coin;
                    if (r_credit != 8'd0) begin
                        w_coin_val = f_change(r_credit);
                        w_state    = PAY;
                    end
                end else if (io_vend.buy) begin
                    w_rej = w_has_coin;
                    if (io_vend.sel > 3'd4 || r_credit < w_price) begin
                        w_err = 1'b1;
                    end else begin
                        w_credit   = r_credit - w_price;
                        w_disp_sel = io_vend.sel;
                        w_state    = DISPENSE;
                    end
                end else if (w_has_coin) begin
                    if (w_sum <= 9'(CREDIT_MAX)) w_credit = w_sum[7:0];
                    else                         w_rej    = 1'b1;
                end
            end
            DISPENSE: begin
                w_rej = w_has_coin;
                if (io_vend.disp_done) begin
                    w_state = IDLE;
                end else if (r_tmo == TW'(DISP_TIMEOUT)) begin
                    // Dispenser never answered: give the customer the price back.
                    w_credit = r_credit + w_dprice;
                    w_err    = 1'b1;
                    w_state  = IDLE;
                end else begin
                    w_tmo = r_tmo + 1'b1;
                end
            end
            CHANGE: begin
                w_rej = w_has_coin;
                if (r_credit == 8'd0) begin
                    w_state = IDLE;
                end else begin
                    w_coin_val = f_change(r_credit);
                    w_state    = PAY;
                end
            end
            PAY: begin
                w_rej = w_has_coin;
                if (r_coin_req && io_vend.coin_ack) begin
                    w_credit = r_credit - {3'd0, r_coin_val};
                    w_state  = CHANGE;
                end
            end
            default: w_state = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= IDLE;
            r_credit   <= 8'd0;
            r_disp_sel <= 3'd0;
            r_coin_val <= 5'd0;
            r_tmo      <= '0;
            r_disp_req <= 1'b0;
            r_coin_req <= 1'b0;
            r_busy     <= 1'b0;
            r_coin_rej <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_credit   <= w_credit;
            r_disp_sel <= w_disp_sel;
            r_coin_val <= w_coin_val;
            r_tmo      <= w_tmo;
            r_disp_req <= (w_state == DISPENSE);
            r_coin_req <= (w_state == PAY);
            r_busy     <= (w_state != IDLE);
            r_coin_rej <= w_rej;
            r_err      <= w_err;
        end
    end

    assign io_vend.disp_req = r_disp_req;
    assign io_vend.disp_sel = r_disp_sel;
    assign io_vend.coin_req = r_coin_req;
    assign io_vend.coin_val = r_coin_val;
    assign io_vend.credit   = r_credit;
    assign io_vend.busy     = r_busy;
    assign io_vend.coin_rej = r_coin_rej;
    assign io_vend.err      = r_err;
endmodule

// File: tb/tb_vend_controller.sv
// Directed bench for vend_controller: coins, purchases, refunds, limits,
// dispense timeout and reset during payout.
module tb_vend_controller;
    localparam int TMO = 16;

    logic clk = 1'b0;
    logic rst;
    int   n_chk  = 0;
    int   n_fail = 0;

    vend_if bus();

    vend_controller #(.DISP_TIMEOUT(TMO)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .io_vend (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic coin(input logic [3:0] c, input logic rej, input int cr);
        bus.coin_in = c;
        tick();
        bus.coin_in = 4'd0;
        chk("coin_rej", 32'(bus.coin_rej), 32'(rej));
        chk("coin_credit", 32'(bus.credit), cr);
    endtask

    // Refund from a known credit; each coin is acked two cycles after coin_req rises.
    task automatic refund_all(input int start);
        int rem;
        int cv;
        int guard;
        rem   = start;
        guard = 0;
        bus.refund = 1'b1;
        tick();
        bus.refund = 1'b0;
        while (rem > 0 && guard < 32) begin
            guard++;
            cv = (rem >= 20) ? 20 : (rem >= 10) ? 10 : (rem >= 5) ? 5 : 1;
            chk("pay_req", 32'(bus.coin_req), 1);
            chk("pay_val", 32'(bus.coin_val), cv);
            tick();
            chk("pay_val_hold", 32'(bus.coin_val), cv);
            bus.coin_ack = 1'b1;
            tick();
            bus.coin_ack = 1'b0;
            rem -= cv;
            chk("ack_req_low", 32'(bus.coin_req), 0);
            chk("ack_credit", 32'(bus.credit), rem);
            chk("ack_busy", 32'(bus.busy), 1);
            tick();
        end
        chk("refund_done_busy", 32'(bus.busy), 0);
        chk("refund_done_req", 32'(bus.coin_req), 0);
    endtask

    initial begin
        int n;
        bus.coin_in = 4'd0; bus.sel = 3'd0; bus.buy = 1'b0; bus.refund = 1'b0;
        bus.disp_done = 1'b0; bus.coin_ack = 1'b0;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        chk("rst_credit", 32'(bus.credit), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_disp_req", 32'(bus.disp_req), 0);
        chk("rst_coin_req", 32'(bus.coin_req), 0);
        chk("rst_coin_val", 32'(bus.coin_val), 0);
        chk("rst_disp_sel", 32'(bus.disp_sel), 0);
        chk("rst_err", 32'(bus.err), 0);

        // Coin accumulation 20+20+10+5+1
        coin(4'b1000, 1'b0, 20);
        coin(4'b1000, 1'b0, 40);
        coin(4'b0100, 1'b0, 50);
        coin(4'b0010, 1'b0, 55);
        coin(4'b0001, 1'b0, 56);

        // Buy product 3 (price 10), coin during dispense is refused
        bus.sel = 3'd3; bus.buy = 1'b1;
        tick();
        bus.buy = 1'b0;
        chk("buy_disp_req", 32'(bus.disp_req), 1);
        chk("buy_busy", 32'(bus.busy), 1);
        chk("buy_credit", 32'(bus.credit), 46);
        chk("buy_disp_sel", 32'(bus.disp_sel), 3);
        chk("buy_err", 32'(bus.err), 0);
        coin(4'b0001, 1'b1, 46);
        chk("disp_hold", 32'(bus.disp_req), 1);
        tick();
        bus.disp_done = 1'b1;
        tick();
        bus.disp_done = 1'b0;
        chk("done_disp_req", 32'(bus.disp_req), 0);
        chk("done_busy", 32'(bus.busy), 0);
        chk("done_credit", 32'(bus.credit), 46);

        // Change 46 -> 20,20,5,1
        refund_all(46);
        chk("refund_credit", 32'(bus.credit), 0);

        // Refund with no credit does nothing
        bus.refund = 1'b1;
        tick();
        bus.refund = 1'b0;
        chk("refund0_req", 32'(bus.coin_req), 0);
        chk("refund0_busy", 32'(bus.busy), 0);

        // Insufficient credit and bad selection
        for (int i = 0; i < 4; i++) coin(4'b0001, 1'b0, i + 1);
        bus.sel = 3'd1; bus.buy = 1'b1;
        tick();
        bus.buy = 1'b0;
        chk("poor_err", 32'(bus.err), 1);
        chk("poor_credit", 32'(bus.credit), 4);
        chk("poor_disp_req", 32'(bus.disp_req), 0);
        tick();
        chk("err_one_cycle", 32'(bus.err), 0);
        bus.sel = 3'd6; bus.buy = 1'b1; bus.coin_in = 4'b0001;
        tick();
        bus.buy = 1'b0; bus.coin_in = 4'd0;
        chk("badsel_err", 32'(bus.err), 1);
        chk("buy_coin_rej", 32'(bus.coin_rej), 1);
        chk("badsel_credit", 32'(bus.credit), 4);

        // Credit ceiling
        coin(4'b1000, 1'b0, 24);
        coin(4'b1000, 1'b0, 44);
        coin(4'b1000, 1'b0, 64);
        coin(4'b0010, 1'b0, 69);
        coin(4'b0001, 1'b0, 70);
        coin(4'b1000, 1'b1, 70);
        coin(4'b0010, 1'b0, 75);
        coin(4'b0010, 1'b1, 75);
        for (int i = 0; i < 4; i++) coin(4'b0001, 1'b0, 76 + i);
        refund_all(79);

        // Multiple coin bits: highest wins
        coin(4'b1001, 1'b0, 20);
        coin(4'b0100, 1'b0, 30);

        // Dispense timeout restores the price
        bus.sel = 3'd4; bus.buy = 1'b1;
        tick();
        bus.buy = 1'b0;
        chk("tmo_credit_dec", 32'(bus.credit), 22);
        n = 0;
        while (bus.disp_req === 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk("tmo_cycles", n, TMO + 1);
        chk("tmo_err", 32'(bus.err), 1);
        chk("tmo_credit", 32'(bus.credit), 30);
        chk("tmo_busy", 32'(bus.busy), 0);
        tick();
        chk("tmo_err_clear", 32'(bus.err), 0);

        // Reset during payout drops the credit
        bus.refund = 1'b1;
        tick();
        bus.refund = 1'b0;
        chk("pay_start_req", 32'(bus.coin_req), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstpay_credit", 32'(bus.credit), 0);
        chk("rstpay_coin_req", 32'(bus.coin_req), 0);
        chk("rstpay_busy", 32'(bus.busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/vend_controller.md
# vend_controller

Transaction sequencer for the vending machine. It accumulates inserted coin credit and validates purchases against the five product prices. It sequences the product dispenser through a request/done handshake and pays change back through a coin-hopper request/acknowledge handshake. It sits between the board inputs (coin switches, buttons) and the credit/price display and LED logic, and it owns the authoritative credit register.

## Interface
Parameters:
- PRICE0..PRICE4, defaults 7, 5, 6, 10, 8: product prices in credit units, 4 bits each.
- CREDIT_MAX, default 79: saturation ceiling for credit.
- DISP_TIMEOUT, default 255: maximum number of cycles to wait for disp_done.

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  reset; synchronous, active-high.
- coin_in  in  4  one-cycle coin pulses; bit0=1, bit1=5, bit2=10, bit3=20.
- sel  in  3  product index 0..4.
- buy  in  1  one-cycle purchase pulse.
- refund  in  1  one-cycle change-return pulse.
- disp_done  in  1  dispenser finished.
- coin_ack  in  1  hopper has ejected the coin on coin_val.
- disp_req  out  1  dispense request.
- disp_sel  out  3  product being dispensed.
- coin_req  out  1  hopper eject request.
- coin_val  out  5  denomination to eject: 20, 10, 5 or 1.
- credit  out  8  current credit.
- busy  out  1  state is not IDLE.
- coin_rej  out  1  one-cycle pulse: coin refused.
- err  out  1  one-cycle pulse: purchase refused or dispense timed out.

## Operation
- States: IDLE, DISPENSE, CHANGE, PAY. All outputs are registered.
- IDLE input handling, in priority order refund > buy > coin:
  - refund with credit>0: go to PAY.
  - refund with credit=0: no-op.
  - buy with sel>4: err pulse.
  - buy with credit<PRICE[sel]: err pulse; credit unchanged.
  - buy otherwise: credit -= PRICE[sel], disp_sel latched, go to DISPENSE.
  - Coin with no refund/buy: the highest set coin_in bit is taken and other bits are ignored. Credit adds the coin value if credit+value ≤ CREDIT_MAX; otherwise coin_rej pulses and credit is unchanged.
  - A coin arriving in the same cycle as refund or buy gets a coin_rej pulse.
- Coins arriving in any non-IDLE state get a coin_rej pulse and are not credited.
- buy or refund arriving in a non-IDLE state is ignored.
- DISPENSE:
  - disp_req is high; a timeout counter runs.
  - disp_done: go to IDLE.
  - Counter reaches DISP_TIMEOUT with no disp_done: credit += PRICE[disp_sel], err pulse, go to IDLE.
- CHANGE:
  - coin_req is low.
  - coin_val = largest of {20, 10, 5, 1} that is ≤ credit.
  - Go to PAY, or to IDLE if credit=0.
- PAY:
  - coin_req is high; coin_val is held stable.
  - On coin_ack: credit -= coin_val, go to CHANGE.
  - coin_ack while coin_req is low is ignored.
- Credit arithmetic is 8-bit unsigned and can never underflow, because subtraction is guarded by the comparisons above.
- Reset:
  - credit=0; state=IDLE.
  - disp_req, coin_req, coin_rej, err and busy are 0; coin_val=0; disp_sel=0.
  - Reset mid-DISPENSE or mid-PAY aborts the transaction and loses the credit.

## Timing
- buy sampled at cycle N:
  - disp_req=1, busy=1 and the decremented credit are all visible at N+1.
  - An err pulse, if any, is high during N+1 only.
- disp_done sampled at cycle M: disp_req=0 and busy=0 at M+1.
- Timeout: disp_req drops in the cycle after the count reaches DISP_TIMEOUT; the credit restore and err pulse occur in that same cycle.
- refund sampled at cycle N: coin_req=1 at N+1, with coin_val already computed from credit.
- coin_ack sampled at cycle M:
  - coin_req=0 and the updated credit appear at M+1.
  - If credit remains, the next coin_req=1 appears at M+2. There is always at least one low cycle between coins.
- When the last coin is acknowledged, busy=0 at M+2.
- coin_rej is high in the cycle after the offending coin pulse.

## Test plan
- Coins 20, 20, 10, 5, 1 on separate cycles -> credit 56, no coin_rej.
- Credit 56; buy with sel=3 -> credit 46 and disp_req at the next cycle; disp_done after 3 cycles -> disp_req low, busy low, credit 46.
- Credit 46; refund, with coin_ack given 2 cycles after each coin_req -> coin_val sequence 20, 20, 5, 1; credit 0; busy low after the final ack.
- Credit 4; buy with sel=1 (price 5) -> err pulse, credit 4, no disp_req. Buy with sel=6 -> err pulse.
- Credit 70; coin 20 -> coin_rej, credit 70. Coin 5 -> credit 75. coin_in=4'b1001 with credit 0 -> credit 20.
- Credit 30; buy with sel=4, disp_done never asserted -> after DISP_TIMEOUT cycles, err pulse, credit 30. rst asserted mid-PAY -> next cycle credit 0, coin_req 0, busy 0.
